// File: rtl/mc_alu_if.sv
// Control bus between the multi-cycle controller and the datapath.
// The controller drives every datapath enable and the ALU operation; the
// datapath supplies the instruction fields and the ALU zero flag.
// There is no valid/ready handshake on this bus: the datapath consumes the
// enables in the same cycle they are presented, and the controller samples
// opcode/funct only while it is in DECODE.
interface mc_alu_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             aluZero;
  logic [2:0]       operation;
  logic             pcEn;
  logic             iorD;
  logic             memRead;
  logic             memWrite;
  logic             irWrite;
  logic             regDst;
  logic             memToReg;
  logic             regWrite;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       pcSrc;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, funct, aluZero,
    output operation, pcEn, iorD, memRead, memWrite, irWrite, regDst,
           memToReg, regWrite, aluSrcA, aluSrcB, pcSrc, illegal, retired,
           state_dbg
  );

  modport slave (
    output opcode, funct, aluZero,
    input  operation, pcEn, iorD, memRead, memWrite, irWrite, regDst,
           memToReg, regWrite, aluSrcA, aluSrcB, pcSrc, illegal, retired,
           state_dbg
  );
endinterface

// File: rtl/mc_alu_controller.sv
// Multi-cycle MIPS control FSM. Outputs are registered from the next state,
// which is equivalent to a Moore decode of the state register. The only
// combinational paths are pcEn in BRANCH (follows aluZero) and the illegal
// pulse in DECODE (follows the live opcode/funct being decoded).
module mc_alu_controller #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mc_alu_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Where DECODE goes for a given encoding; unsupported ones return to FETCH.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
    state_t t;
    t = S_FETCH;
    case (op)
      OPC_RTYPE: if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                     fn == FN_OR  || fn == FN_SLT) t = S_R_EXEC;
      OPC_LW, OPC_SW:     t = S_MEM_ADDR;
      OPC_BEQ:            t = S_BRANCH;
      OPC_ADDI, OPC_SLTI: t = S_I_EXEC;
      OPC_J:              t = S_JUMP;
      default:            t = S_FETCH;
    endcase
    return t;
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      FN_ADD:  a = ALU_ADD;
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_NOP;
    endcase
    return a;
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       fn_q, fn_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [2:0]       operation_q, operation_d;
  logic             pc_en_q, pc_en_d;
  logic             iord_q, iord_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             ir_write_q, ir_write_d;
  logic             reg_dst_q, reg_dst_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             reg_write_q, reg_write_d;
  logic             alu_src_a_q, alu_src_a_d;
  logic [1:0]       alu_src_b_q, alu_src_b_d;
  logic [1:0]       pc_src_q, pc_src_d;

  // Next state, latched IR fields, retire count, then outputs for the next state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fn_d        = fn_q;
    retired_d   = retired_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        op_d    = bus.opcode;
        fn_d    = bus.funct;
        state_d = decode_target(bus.opcode, bus.funct);
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_MEM_ADDR: state_d = (op_q == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_R_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_I_WB, S_JUMP: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 1'b1;
      end
      default:    state_d = S_IDLE;
    endcase

    operation_d  = ALU_NOP;
    pc_en_d      = 1'b0;
    iord_d       = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    pc_src_d     = 2'b00;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        operation_d = ALU_ADD;
        pc_en_d     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b_d = 2'b11;
        operation_d = ALU_ADD;
      end
      S_R_EXEC: begin
        alu_src_a_d = 1'b1;
        operation_d = alu_for_funct(fn_d);
      end
      S_R_WB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        operation_d = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      // pcEn here comes from aluZero on the output path, not from a flop.
      S_BRANCH: begin
        alu_src_a_d = 1'b1;
        operation_d = ALU_SUB;
        pc_src_d    = 2'b01;
      end
      S_I_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        operation_d = (op_d == OPC_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB:  reg_write_d = 1'b1;
      S_JUMP: begin
        pc_src_d = 2'b10;
        pc_en_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, IR latch, retire counter and registered outputs; async reset clears all strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      fn_q         <= '0;
      retired_q    <= '0;
      operation_q  <= ALU_NOP;
      pc_en_q      <= 1'b0;
      iord_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      pc_src_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      fn_q         <= fn_d;
      retired_q    <= retired_d;
      operation_q  <= operation_d;
      pc_en_q      <= pc_en_d;
      iord_q       <= iord_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ir_write_q   <= ir_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      pc_src_q     <= pc_src_d;
    end
  end

  assign bus.operation = operation_q;
  assign bus.pcEn      = pc_en_q | ((state_q == S_BRANCH) & bus.aluZero);
  assign bus.iorD      = iord_q;
  assign bus.memRead   = mem_read_q;
  assign bus.memWrite  = mem_write_q;
  assign bus.irWrite   = ir_write_q;
  assign bus.regDst    = reg_dst_q;
  assign bus.memToReg  = mem_to_reg_q;
  assign bus.regWrite  = reg_write_q;
  assign bus.aluSrcA   = alu_src_a_q;
  assign bus.aluSrcB   = alu_src_b_q;
  assign bus.pcSrc     = pc_src_q;
  assign bus.illegal   = (state_q == S_DECODE) &&
                         (decode_target(bus.opcode, bus.funct) == S_FETCH);
  assign bus.retired   = retired_q;
  assign bus.state_dbg = state_q;

endmodule
